// File: rtl/sobel_sharpen_cfg_if.sv
// ---------------------------------------------------------------------------
// Module  : sobel_sharpen_cfg_if
// Brief   : 3x3 window input bus and processed-pixel output bus of the Sobel stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sobel_sharpen_cfg_if #(
  parameter int DATA_W = 8
);
  logic              matrix_img_vsync;
  logic              matrix_img_hsync;
  logic              matrix_img_valid;
  logic              matrix_edge_flag;
  logic [DATA_W-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DATA_W-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DATA_W-1:0] matrix_p31, matrix_p32, matrix_p33;
  logic              post_img_vsync;
  logic              post_img_hsync;
  logic              post_img_valid;
  logic [DATA_W-1:0] post_img_data;

  modport master (
    output matrix_img_vsync, matrix_img_hsync, matrix_img_valid, matrix_edge_flag,
    output matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    input  post_img_vsync, post_img_hsync, post_img_valid, post_img_data
  );

  modport slave (
    input  matrix_img_vsync, matrix_img_hsync, matrix_img_valid, matrix_edge_flag,
    input  matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    output post_img_vsync, post_img_hsync, post_img_valid, post_img_data
  );
endinterface

`default_nettype wire

// File: rtl/sobel_sharpen_cfg.sv
// ---------------------------------------------------------------------------
// Module  : sobel_sharpen_cfg
// Brief   : Sobel gradient / sharpen stage with frame-synchronous config and
//           per-frame saturation count. SOBEL_SHARPEN_L2_EN selects L2 magnitude.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sobel_sharpen_cfg #(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 4,
  parameter int SHIFT  = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [1:0]        cfg_mode,
  input  wire logic [GAIN_W-1:0] cfg_gain,
  input  wire logic [DATA_W-1:0] cfg_thresh,
  sobel_sharpen_cfg_if.slave     vif,
  output logic [15:0]            frame_sat_cnt
);

  localparam int c_SW  = DATA_W + 2;
  localparam int c_DW  = DATA_W + 3;
  localparam int c_SCW = c_DW + GAIN_W;
  localparam int c_RW  = c_SCW + 1;
  localparam logic [DATA_W-1:0] c_MAX = '1;
`ifdef SOBEL_SHARPEN_L2_EN
  localparam int c_RADW     = 2 * c_DW;
  localparam int c_REMW     = c_DW + 2;
  localparam int c_MAG_STG  = 4 + c_DW;
`else
  localparam int c_MAG_STG  = 4;
`endif

  typedef struct packed {
    logic              vs;
    logic              hs;
    logic              vld;
    logic              edf;
    logic [DATA_W-1:0] p22;
    logic [1:0]        mode;
    logic [GAIN_W-1:0] gain;
    logic [DATA_W-1:0] thr;
  } sb_t;

  // Frame-synchronous config shadow; the rising-vsync pixel already sees the new values.
  logic              r_vs_in_d;
  logic [1:0]        r_mode;
  logic [GAIN_W-1:0] r_gain;
  logic [DATA_W-1:0] r_thr;
  logic              w_vs_rise;
  sb_t               w_sb_in;

  assign w_vs_rise = vif.matrix_img_vsync & ~r_vs_in_d;
  assign w_sb_in   = {vif.matrix_img_vsync, vif.matrix_img_hsync, vif.matrix_img_valid,
                      vif.matrix_edge_flag, vif.matrix_p22,
                      w_vs_rise ? cfg_mode   : r_mode,
                      w_vs_rise ? cfg_gain   : r_gain,
                      w_vs_rise ? cfg_thresh : r_thr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_in_d <= 1'b0;
      r_mode    <= 2'd0;
      r_gain    <= GAIN_W'(1 << SHIFT);
      r_thr     <= c_MAX;
    end else begin
      r_vs_in_d <= vif.matrix_img_vsync;
      if (w_vs_rise) begin
        r_mode <= cfg_mode;
        r_gain <= cfg_gain;
        r_thr  <= cfg_thresh;
      end
    end
  end

  sb_t r_sb [c_MAG_STG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_MAG_STG; i++) r_sb[i] <= '0;
    end else begin
      r_sb[0] <= w_sb_in;
      for (int i = 1; i < c_MAG_STG; i++) r_sb[i] <= r_sb[i-1];
    end
  end

  logic        [c_SW-1:0] r_gx1, r_gx2, r_gy1, r_gy2;
  logic signed [c_DW-1:0] r_gx, r_gy;
  logic        [c_SW-1:0] w_ax, w_ay;
  logic        [c_DW-1:0] w_mag;

  always_ff @(posedge clk) begin
    r_gx1 <= c_SW'(vif.matrix_p13) + (c_SW'(vif.matrix_p23) << 1) + c_SW'(vif.matrix_p33);
    r_gx2 <= c_SW'(vif.matrix_p11) + (c_SW'(vif.matrix_p21) << 1) + c_SW'(vif.matrix_p31);
    r_gy1 <= c_SW'(vif.matrix_p31) + (c_SW'(vif.matrix_p32) << 1) + c_SW'(vif.matrix_p33);
    r_gy2 <= c_SW'(vif.matrix_p11) + (c_SW'(vif.matrix_p12) << 1) + c_SW'(vif.matrix_p13);
    r_gx  <= $signed({1'b0, r_gx1}) - $signed({1'b0, r_gx2});
    r_gy  <= $signed({1'b0, r_gy1}) - $signed({1'b0, r_gy2});
  end

  assign w_ax = r_gx[c_DW-1] ? c_SW'(-r_gx) : c_SW'(r_gx);
  assign w_ay = r_gy[c_DW-1] ? c_SW'(-r_gy) : c_SW'(r_gy);

`ifdef SOBEL_SHARPEN_L2_EN
  logic [c_RADW-1:0] r_sqx, r_sqy, r_rad;
  logic [c_RADW-1:0] r_sq_rad  [c_DW];
  logic [c_REMW-1:0] r_sq_rem  [c_DW];
  logic [c_DW-1:0]   r_sq_root [c_DW];

  // One restoring step: append two radicand bits, try subtracting 4*root+1.
  function automatic logic [c_REMW+c_DW-1:0] sq_step(input logic [c_REMW-1:0] rem,
                                                     input logic [c_DW-1:0]   root,
                                                     input logic [1:0]        bits);
    logic [c_REMW+1:0] pre;
    logic [c_REMW+1:0] trial;
    pre   = {rem, bits};
    trial = (c_REMW + 2)'({root, 2'b01});
    if (pre >= trial) return {c_REMW'(pre - trial), root[c_DW-2:0], 1'b1};
    else              return {c_REMW'(pre), root[c_DW-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    r_sqx <= c_RADW'(w_ax) * c_RADW'(w_ax);
    r_sqy <= c_RADW'(w_ay) * c_RADW'(w_ay);
    r_rad <= r_sqx + r_sqy;
    r_sq_rad[0] <= r_rad;
    {r_sq_rem[0], r_sq_root[0]} <= sq_step('0, '0, r_rad[2*(c_DW-1) +: 2]);
    for (int k = 1; k < c_DW; k++) begin
      r_sq_rad[k] <= r_sq_rad[k-1];
      {r_sq_rem[k], r_sq_root[k]} <= sq_step(r_sq_rem[k-1], r_sq_root[k-1],
                                             r_sq_rad[k-1][2*(c_DW-1-k) +: 2]);
    end
  end

  assign w_mag = r_sq_root[c_DW-1];
`else
  logic [c_SW-1:0] r_ax, r_ay;
  logic [c_DW-1:0] r_mag;

  always_ff @(posedge clk) begin
    r_ax  <= w_ax;
    r_ay  <= w_ay;
    r_mag <= c_DW'(r_ax) + c_DW'(r_ay);
  end

  assign w_mag = r_mag;
`endif

  sb_t w_sb_mag;
  assign w_sb_mag = r_sb[c_MAG_STG-1];

  logic              r_p1_vs, r_p1_hs, r_p1_vld, r_p1_edf;
  logic [DATA_W-1:0] r_p1_p22, r_p1_thr;
  logic [1:0]        r_p1_mode;
  logic [c_SCW-1:0]  r_p1_sc;
  logic              r_p2_vs, r_p2_hs, r_p2_vld;
  logic [1:0]        r_p2_mode;
  logic [c_RW-1:0]   r_p2_r;
  logic [c_RW-1:0]   w_r;
  logic              w_sat;
  logic              r_p3_sat;

  always_comb begin
    w_r = '0;
    case (r_p1_mode)
      2'd0:    w_r = c_RW'(r_p1_p22);
      2'd1:    w_r = r_p1_edf ? c_RW'(r_p1_p22) : c_RW'(r_p1_p22) + c_RW'(r_p1_sc);
      2'd2:    w_r = r_p1_edf ? '0 : c_RW'(r_p1_sc);
      default: w_r = (!r_p1_edf && (r_p1_sc >= c_SCW'(r_p1_thr))) ? c_RW'(c_MAX) : '0;
    endcase
  end

  assign w_sat = r_p2_vld && ((r_p2_mode == 2'd1) || (r_p2_mode == 2'd2)) &&
                 (r_p2_r > c_RW'(c_MAX));

  always_ff @(posedge clk) begin
    r_p1_p22  <= w_sb_mag.p22;
    r_p1_thr  <= w_sb_mag.thr;
    r_p1_mode <= w_sb_mag.mode;
    r_p1_edf  <= w_sb_mag.edf;
    r_p1_sc   <= (c_SCW'(w_mag) * c_SCW'(w_sb_mag.gain)) >> SHIFT;
    r_p2_mode <= r_p1_mode;
    r_p2_r    <= w_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_p1_vs, r_p1_hs, r_p1_vld} <= 3'b000;
      {r_p2_vs, r_p2_hs, r_p2_vld} <= 3'b000;
      vif.post_img_vsync <= 1'b0;
      vif.post_img_hsync <= 1'b0;
      vif.post_img_valid <= 1'b0;
      vif.post_img_data  <= '0;
      r_p3_sat           <= 1'b0;
    end else begin
      {r_p1_vs, r_p1_hs, r_p1_vld} <= {w_sb_mag.vs, w_sb_mag.hs, w_sb_mag.vld};
      {r_p2_vs, r_p2_hs, r_p2_vld} <= {r_p1_vs, r_p1_hs, r_p1_vld};
      vif.post_img_vsync <= r_p2_vs;
      vif.post_img_hsync <= r_p2_hs;
      vif.post_img_valid <= r_p2_vld;
      vif.post_img_data  <= (r_p2_r > c_RW'(c_MAX)) ? c_MAX : r_p2_r[DATA_W-1:0];
      r_p3_sat           <= w_sat;
    end
  end

  // Counter runs on the output side so frames are split exactly at the delayed vsync.
  logic        r_pvs_d;
  logic [15:0] r_run;
  logic        w_pvs_rise;

  assign w_pvs_rise = vif.post_img_vsync & ~r_pvs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pvs_d       <= 1'b0;
      r_run         <= '0;
      frame_sat_cnt <= '0;
    end else begin
      r_pvs_d <= vif.post_img_vsync;
      if (w_pvs_rise) begin
        frame_sat_cnt <= r_run;
        r_run         <= {15'd0, r_p3_sat};
      end else if (r_p3_sat && (r_run != 16'hFFFF)) begin
        r_run <= r_run + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire
